// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I instruction encoder: opcodes, request classes, FSM states.
package rv_pkg;

    // Opcode values match the ones the core's decoder expects.
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    typedef enum logic [2:0] {
        ClsR      = 3'd0,
        ClsI      = 3'd1,
        ClsLoad   = 3'd2,
        ClsStore  = 3'd3,
        ClsBranch = 3'd4
    } instrClass_t;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StFull
    } encState_t;

    // True when a 13-bit immediate fits in a 12-bit signed field.
    function automatic logic fitsImm12(input logic [12:0] imm);
        return imm[12] == imm[11];
    endfunction

endpackage

// File: rtl/rv_instr_pack.sv
// Combinational packer: turns decoded fields into an RV32I word and flags illegal requests.
module rv_instr_pack
    import rv_pkg::*;
(
    input  logic [2:0]  cls,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [12:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (cls)
            ClsR: begin
                word  = {funct7, rs2, rs1, funct3, rd, OpR};
                legal = 1'b1;
            end
            ClsI: begin
                word  = {imm[11:0], rs1, funct3, rd, OpImm};
                legal = fitsImm12(imm);
            end
            ClsLoad: begin
                word  = {imm[11:0], rs1, funct3, rd, OpLoad};
                legal = fitsImm12(imm);
            end
            ClsStore: begin
                word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], OpStore};
                legal = fitsImm12(imm);
            end
            ClsBranch: begin
                // Branch offsets are halfword aligned; bit 0 is never encoded.
                word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OpBranch};
                legal = ~imm[0];
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rv32_instr_encoder.sv
// Program loader: accepts decoded instruction fields, encodes them and writes them sequentially
// into instruction memory, one word per two cycles, until the address space is full.
module rv32_instr_encoder
    import rv_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [12:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              err,
    output logic              full
);

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   CountOne = {{ADDR_W{1'b0}}, 1'b1};

    encState_t         stateQ, stateD;
    logic [ADDR_W-1:0] addrQ, addrD;
    logic [ADDR_W:0]   countQ, countD;
    logic [31:0]       wdataQ, wdataD;
    logic              weQ, weD;
    logic              errQ, errD;

    logic [31:0] packedWord;
    logic        packedLegal;
    logic        accept;

    rv_instr_pack u_pack (
        .cls    (in_class),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .imm    (in_imm),
        .word   (packedWord),
        .legal  (packedLegal)
    );

    assign in_ready = (stateQ == StIdle);
    assign full     = (stateQ == StFull);
    assign accept   = in_valid && in_ready;

    always_comb begin
        stateD = stateQ;
        addrD  = addrQ;
        countD = countQ;
        wdataD = wdataQ;
        weD    = 1'b0;
        errD   = 1'b0;

        if (clear) begin
            // A strobe already on the outputs still completes, but is not counted.
            stateD = StIdle;
            addrD  = BaseAddr;
            countD = '0;
        end else begin
            case (stateQ)
                StIdle: begin
                    if (accept) begin
                        if (packedLegal) begin
                            wdataD = packedWord;
                            weD    = 1'b1;
                            stateD = StWrite;
                        end else begin
                            errD = 1'b1;
                        end
                    end
                end
                StWrite: begin
                    countD = countQ + CountOne;
                    if (&addrQ) begin
                        stateD = StFull;
                    end else begin
                        addrD  = addrQ + 1'b1;
                        stateD = StIdle;
                    end
                end
                StFull: begin
                    stateD = StFull;
                end
                default: begin
                    stateD = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= StIdle;
            addrQ  <= BaseAddr;
            countQ <= '0;
            wdataQ <= '0;
            weQ    <= 1'b0;
            errQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            addrQ  <= addrD;
            countQ <= countD;
            wdataQ <= wdataD;
            weQ    <= weD;
            errQ   <= errD;
        end
    end

    assign imem_we    = weQ;
    assign imem_addr  = addrQ;
    assign imem_wdata = wdataQ;
    assign count      = countQ;
    assign err        = errQ;

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Scoreboard bench for rv32_instr_encoder: a driver pushes expected writes/errors, a monitor
// pops and compares them whenever the DUT strobes imem_we or err.
module tb_rv32_instr_encoder;

    localparam int AW = 2;
    localparam int LastAddr = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_class;
    logic [4:0]    in_rd, in_rs1, in_rs2;
    logic [2:0]    in_funct3;
    logic [6:0]    in_funct7;
    logic [12:0]   in_imm;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          err;
    logic          full;

    rv32_instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_class   (in_class),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .err        (err),
        .full       (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          isErr;
        int          addr;
        logic [31:0] data;
    } ev_t;

    ev_t expQ[$];
    int  nChecks = 0;
    int  nFails  = 0;
    int  mAddr   = 0;
    int  mCount  = 0;
    bit  mFull   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder built from the instruction-format bit positions with integer arithmetic.
    function automatic bit modelEncode(input int cls, input int rd, input int rs1, input int rs2,
                                       input int f3, input int f7, input int imm13,
                                       output logic [31:0] w);
        int s;
        int common;
        s = (imm13 >= 4096) ? imm13 - 8192 : imm13;
        common = (rs1 << 15) | (f3 << 12);
        case (cls)
            0: begin
                w = (f7 << 25) | (rs2 << 20) | common | (rd << 7) | 'h33;
                return 1'b1;
            end
            1, 2: begin
                w = ((s & 'hfff) << 20) | common | (rd << 7) | ((cls == 1) ? 'h13 : 'h03);
                return (s >= -2048) && (s <= 2047);
            end
            3: begin
                w = (((s >> 5) & 'h7f) << 25) | (rs2 << 20) | common | ((s & 'h1f) << 7) | 'h23;
                return (s >= -2048) && (s <= 2047);
            end
            4: begin
                w = (((s >> 12) & 1) << 31) | (((s >> 5) & 'h3f) << 25) | (rs2 << 20) | common
                    | (((s >> 1) & 'hf) << 8) | (((s >> 11) & 1) << 7) | 'h63;
                return (imm13 % 2) == 0;
            end
            default: begin
                w = '0;
                return 1'b0;
            end
        endcase
    endfunction

    task automatic send(input int cls, input int rd, input int rs1, input int rs2, input int f3,
                        input int f7, input int imm, input bit useExp = 0,
                        input logic [31:0] expW = 32'h0);
        bit          ok;
        bit          legal;
        logic [31:0] w;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            check("ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        check("count_idle", 64'(count), 64'(mCount));
        check("addr_idle", 64'(imem_addr), 64'(mAddr));
        check("full_idle", 64'(full), 64'd0);
        in_class  = 3'(cls);
        in_rd     = 5'(rd);
        in_rs1    = 5'(rs1);
        in_rs2    = 5'(rs2);
        in_funct3 = 3'(f3);
        in_funct7 = 7'(f7);
        in_imm    = 13'(imm);
        in_valid  = 1'b1;
        legal = modelEncode(cls, rd, rs1, rs2, f3, f7, imm, w);
        if (useExp) w = expW;
        if (legal) begin
            expQ.push_back('{1'b0, mAddr, w});
            mCount++;
            if (mAddr == LastAddr) mFull = 1;
            else mAddr++;
        end else begin
            expQ.push_back('{1'b1, mAddr, 32'h0});
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic doClear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        mAddr = 0;
        mCount = 0;
        mFull = 0;
        @(negedge clk);
        check("clear_count", 64'(count), 64'd0);
        check("clear_addr", 64'(imem_addr), 64'd0);
        check("clear_ready", 64'(in_ready), 64'd1);
        check("clear_full", 64'(full), 64'd0);
    endtask

    // Monitor: every strobe must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst && (imem_we || err)) begin
            if (expQ.size() == 0) begin
                check("unexpected_strobe", {62'd0, imem_we, err}, 64'd0);
            end else begin
                ev_t e;
                e = expQ.pop_front();
                check("event_is_write", 64'(imem_we), 64'(!e.isErr));
                check("event_addr", 64'(imem_addr), 64'(e.addr));
                if (!e.isErr) check("event_wdata", 64'(imem_wdata), 64'(e.data));
                else check("err_ready", 64'(in_ready), 64'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
        in_class = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        #12;
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_we", 64'(imem_we), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        check("rst_wdata", 64'(imem_wdata), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors with known encodings
        send(0, 3, 1, 2, 0, 'h20, 0, 1, 32'h402081B3);
        doClear();
        send(1, 5, 0, 0, 0, 0, 'h1FFF, 1, 32'hFFF00293);
        send(2, 6, 5, 0, 2, 0, 8, 1, 32'h0082A303);
        send(3, 0, 5, 6, 2, 0, 4, 1, 32'h0062A223);
        send(4, 0, 1, 2, 0, 0, 'h1FFC, 1, 32'hFE208EE3);

        // Fifth request must be held while full
        @(negedge clk);
        @(negedge clk);
        in_class = 3'd0; in_rd = 5'd1; in_valid = 1'b1;
        repeat (4) @(negedge clk);
        check("full_flag", 64'(full), 64'd1);
        check("full_ready", 64'(in_ready), 64'd0);
        check("full_count", 64'(count), 64'd4);
        check("full_addr", 64'(imem_addr), 64'(LastAddr));
        doClear();

        // Rejected requests
        send(4, 0, 1, 2, 0, 0, 3);
        send(1, 1, 1, 0, 0, 0, 'h0800);
        send(6, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        check("err_keeps_ready", 64'(in_ready), 64'd1);
        check("err_no_count", 64'(count), 64'd0);

        // Reset during a write strobe
        send(0, 7, 7, 7, 7, 7, 0);
        #1 rst = 1'b1;
        #1;
        check("rstw_we", 64'(imem_we), 64'd0);
        check("rstw_addr", 64'(imem_addr), 64'd0);
        check("rstw_wdata", 64'(imem_wdata), 64'd0);
        check("rstw_count", 64'(count), 64'd0);
        check("rstw_ready", 64'(in_ready), 64'd1);
        check("rstw_full", 64'(full), 64'd0);
        check("rstw_err", 64'(err), 64'd0);
        expQ.delete();
        mAddr = 0; mCount = 0; mFull = 0;
        @(negedge clk);
        rst = 1'b0;
        send(0, 9, 10, 11, 5, 'h15, 0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 150; n++) begin
            if (mFull) begin
                repeat (2) @(negedge clk);
                check("rand_full", 64'(full), 64'd1);
                check("rand_full_ready", 64'(in_ready), 64'd0);
                doClear();
            end else if ($urandom_range(0, 19) == 0) begin
                doClear();
            end else begin
                int cls;
                int imm;
                cls = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 4))
                                                 : int'($urandom_range(5, 7));
                case ($urandom_range(0, 2))
                    0: imm = int'($urandom_range(0, 8191));
                    1: imm = int'($urandom_range(0, 2047));
                    default: imm = int'($urandom_range(6144, 8191));
                endcase
                send(cls, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 127)), imm);
            end
        end

        repeat (4) @(negedge clk);
        check("queue_drained", 64'(expQ.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
